// File: rtl/id_ex_forward.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand bypass and load-use bubble insertion.
// Optional: define ID_EX_LOADUSE_CNT_EN to add a saturating LoadUseCount output.
module id_ex_forward #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              IdValid,
  input  logic [DATA_W-1:0] IdRsData,
  input  logic [DATA_W-1:0] IdRtData,
  input  logic [DATA_W-1:0] IdImm,
  input  logic [REG_AW-1:0] IdRs,
  input  logic [REG_AW-1:0] IdRt,
  input  logic [REG_AW-1:0] IdWriteReg,
  input  logic [CTRL_W-1:0] IdALUControl,
  input  logic              IdALUSrc,
  input  logic              IdRegWrite,
  input  logic              IdMemRead,
  input  logic              IdMemWrite,
  input  logic              IdMemToReg,
  input  logic              MemRegWrite,
  input  logic [REG_AW-1:0] MemRd,
  input  logic [DATA_W-1:0] MemALUResult,
  input  logic              WbRegWrite,
  input  logic [REG_AW-1:0] WbRd,
  input  logic [DATA_W-1:0] WbData,
  output logic [CTRL_W-1:0] ALUControl,
  output logic [DATA_W-1:0] I0,
  output logic [DATA_W-1:0] I1,
  output logic [DATA_W-1:0] ExStoreData,
  output logic [REG_AW-1:0] ExWriteReg,
  output logic              ExValid,
  output logic              ExRegWrite,
  output logic              ExMemRead,
  output logic              ExMemWrite,
  output logic              ExMemToReg,
  output logic              LoadUseStall
`ifdef ID_EX_LOADUSE_CNT_EN
  ,
  output logic [15:0]       LoadUseCount
`endif
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] write_reg;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_t;

  ex_t               ex_q;
  ex_t               id_d;
  logic              mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  logic              load_use;

  // Bypass select: EX/MEM beats MEM/WB, register 0 is never forwarded.
  assign mem_hit_rs = MemRegWrite && (MemRd != '0) && (MemRd == ex_q.rs);
  assign mem_hit_rt = MemRegWrite && (MemRd != '0) && (MemRd == ex_q.rt);
  assign wb_hit_rs  = WbRegWrite  && (WbRd  != '0) && (WbRd  == ex_q.rs);
  assign wb_hit_rt  = WbRegWrite  && (WbRd  != '0) && (WbRd  == ex_q.rt);

  assign fwd_rs = mem_hit_rs ? MemALUResult : (wb_hit_rs ? WbData : ex_q.rs_data);
  assign fwd_rt = mem_hit_rt ? MemALUResult : (wb_hit_rt ? WbData : ex_q.rt_data);

  // Conservative: rt match counts even when the ID instruction ignores rt.
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.write_reg != '0) && IdValid &&
                    ((ex_q.write_reg == IdRs) || (ex_q.write_reg == IdRt));

  always_comb begin
    id_d            = '0;
    id_d.valid      = IdValid;
    id_d.rs_data    = IdRsData;
    id_d.rt_data    = IdRtData;
    id_d.imm        = IdImm;
    id_d.rs         = IdRs;
    id_d.rt         = IdRt;
    id_d.write_reg  = IdWriteReg;
    id_d.alu_ctrl   = IdALUControl;
    id_d.alu_src    = IdALUSrc;
    id_d.reg_write  = IdRegWrite;
    id_d.mem_read   = IdMemRead;
    id_d.mem_write  = IdMemWrite;
    id_d.mem_to_reg = IdMemToReg;
  end

  // While stalled, operands keep absorbing bypass values so a retiring producer is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (Flush) begin
      ex_q <= '0;
    end else if (Stall) begin
      ex_q.rs_data <= fwd_rs;
      ex_q.rt_data <= fwd_rt;
    end else if (load_use) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_d;
    end
  end

`ifdef ID_EX_LOADUSE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_use && !Stall && !Flush && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign LoadUseCount = cnt_q;
`endif

  assign ALUControl   = ex_q.alu_ctrl;
  assign I0           = fwd_rs;
  assign I1           = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign ExStoreData  = fwd_rt;
  assign ExWriteReg   = ex_q.write_reg;
  assign ExValid      = ex_q.valid;
  assign ExRegWrite   = ex_q.reg_write;
  assign ExMemRead    = ex_q.mem_read;
  assign ExMemWrite   = ex_q.mem_write;
  assign ExMemToReg   = ex_q.mem_to_reg;
  assign LoadUseStall = load_use;

endmodule

// File: tb/tb_id_ex_forward.sv
// Randomized bench for id_ex_forward against an instruction-level model, plus directed literal checks.
module tb_id_ex_forward;

  logic        clk = 1'b0;
  logic        rst_n, Stall, Flush, IdValid;
  logic [31:0] IdRsData, IdRtData, IdImm;
  logic [4:0]  IdRs, IdRt, IdWriteReg;
  logic [3:0]  IdALUControl;
  logic        IdALUSrc, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg;
  logic        MemRegWrite, WbRegWrite;
  logic [4:0]  MemRd, WbRd;
  logic [31:0] MemALUResult, WbData;
  logic [3:0]  ALUControl;
  logic [31:0] I0, I1, ExStoreData;
  logic [4:0]  ExWriteReg;
  logic        ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, LoadUseStall;
`ifdef ID_EX_LOADUSE_CNT_EN
  logic [15:0] LoadUseCount;
  logic [15:0] m_cnt = '0;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_forward dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush), .IdValid(IdValid),
    .IdRsData(IdRsData), .IdRtData(IdRtData), .IdImm(IdImm),
    .IdRs(IdRs), .IdRt(IdRt), .IdWriteReg(IdWriteReg), .IdALUControl(IdALUControl),
    .IdALUSrc(IdALUSrc), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdMemWrite(IdMemWrite), .IdMemToReg(IdMemToReg),
    .MemRegWrite(MemRegWrite), .MemRd(MemRd), .MemALUResult(MemALUResult),
    .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbData(WbData),
    .ALUControl(ALUControl), .I0(I0), .I1(I1), .ExStoreData(ExStoreData),
    .ExWriteReg(ExWriteReg), .ExValid(ExValid), .ExRegWrite(ExRegWrite),
    .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExMemToReg(ExMemToReg),
    .LoadUseStall(LoadUseStall)
`ifdef ID_EX_LOADUSE_CNT_EN
    , .LoadUseCount(LoadUseCount)
`endif
  );

  // Instruction sitting in EX, as the model sees it.
  typedef struct packed {
    logic        v;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, wr;
    logic [3:0]  alu;
    logic        src, rw, mr, mw, m2r;
  } instr_t;

  instr_t m = '0;

  function automatic logic [31:0] m_fwd(input logic [4:0] src, input logic [31:0] held);
    if (src == 5'd0) return held;
    if (MemRegWrite && MemRd == src) return MemALUResult;
    if (WbRegWrite && WbRd == src) return WbData;
    return held;
  endfunction

  function automatic logic m_hazard();
    return m.v && m.mr && m.wr != 5'd0 && IdValid && (m.wr == IdRs || m.wr == IdRt);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m <= '0;
`ifdef ID_EX_LOADUSE_CNT_EN
      m_cnt <= '0;
`endif
    end else if (Flush) begin
      m <= '0;
    end else if (Stall) begin
      m.rsd <= m_fwd(m.rs, m.rsd);
      m.rtd <= m_fwd(m.rt, m.rtd);
    end else if (m_hazard()) begin
      m <= '0;
`ifdef ID_EX_LOADUSE_CNT_EN
      if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
`endif
    end else begin
      m <= '{IdValid, IdRsData, IdRtData, IdImm, IdRs, IdRt, IdWriteReg, IdALUControl,
             IdALUSrc, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg};
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("I0", I0, m_fwd(m.rs, m.rsd));
      check("I1", I1, m.src ? m.imm : m_fwd(m.rt, m.rtd));
      check("ExStoreData", ExStoreData, m_fwd(m.rt, m.rtd));
      check("ALUControl", 32'(ALUControl), 32'(m.alu));
      check("ExWriteReg", 32'(ExWriteReg), 32'(m.wr));
      check("ExCtrl", 32'({ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg}),
            32'({m.v, m.rw, m.mr, m.mw, m.m2r}));
      check("LoadUseStall", 32'(LoadUseStall), 32'(m_hazard()));
`ifdef ID_EX_LOADUSE_CNT_EN
      check("LoadUseCount", 32'(LoadUseCount), 32'(m_cnt));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Stall = 0; Flush = 0; IdValid = 0;
    IdRsData = '0; IdRtData = '0; IdImm = '0;
    IdRs = '0; IdRt = '0; IdWriteReg = '0; IdALUControl = '0;
    IdALUSrc = 0; IdRegWrite = 0; IdMemRead = 0; IdMemWrite = 0; IdMemToReg = 0;
    MemRegWrite = 0; MemRd = '0; MemALUResult = '0;
    WbRegWrite = 0; WbRd = '0; WbData = '0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic [3:0] alu, input logic src, input logic mr);
    IdValid = 1; IdRs = rs; IdRt = rt; IdWriteReg = wr;
    IdRsData = rsd; IdRtData = rtd; IdImm = imm; IdALUControl = alu;
    IdALUSrc = src; IdRegWrite = 1; IdMemRead = mr; IdMemToReg = mr; IdMemWrite = 0;
  endtask

  task automatic rand_inputs();
    rst_n = ($urandom_range(49) != 0);
    Flush = ($urandom_range(15) == 0);
    Stall = ($urandom_range(7) == 0);
    IdValid = ($urandom_range(3) != 0);
    IdRsData = $urandom; IdRtData = $urandom; IdImm = $urandom;
    IdRs = 5'($urandom_range(7)); IdRt = 5'($urandom_range(7));
    IdWriteReg = 5'($urandom_range(7)); IdALUControl = 4'($urandom);
    IdALUSrc = 1'($urandom); IdRegWrite = 1'($urandom);
    IdMemRead = ($urandom_range(2) == 0); IdMemWrite = 1'($urandom); IdMemToReg = 1'($urandom);
    MemRegWrite = 1'($urandom); MemRd = 5'($urandom_range(7)); MemALUResult = $urandom;
    WbRegWrite = 1'($urandom); WbRd = 5'($urandom_range(7)); WbData = $urandom;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    IdValid = 1; IdRsData = $urandom; IdRtData = $urandom; IdRs = 5'd3; IdALUControl = 4'b0010;
    IdRegWrite = 1; IdMemRead = 1;
    tick();
    chk_en = 1;
    tick();
    @(negedge clk);
    check("rst_ExValid", 32'(ExValid), 32'd0);
    check("rst_I0", I0, 32'd0);
    check("rst_I1", I1, 32'd0);
    check("rst_LoadUseStall", 32'(LoadUseStall), 32'd0);

    // Release: next edge loads a sub.
    rst_n = 1;
    instr(5'd1, 5'd2, 5'd9, 32'd11, 32'd22, 32'd0, 4'b0110, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    check("load_ExValid", 32'(ExValid), 32'd1);
    check("load_ALUControl", 32'(ALUControl), 32'h6);
    check("load_I0", I0, 32'd11);

    // EX/MEM has priority over MEM/WB; register 0 never forwarded.
    tick();
    instr(5'd3, 5'd4, 5'd10, 32'd5, 32'd7, 32'd0, 4'b0010, 1'b0, 1'b0);
    tick();
    MemRegWrite = 1; MemRd = 5'd3; MemALUResult = 32'd100;
    WbRegWrite = 1; WbRd = 5'd3; WbData = 32'd200;
    @(negedge clk);
    check("fwd_mem_I0", I0, 32'd100);
    check("fwd_mem_I1", I1, 32'd7);
    tick();
    instr(5'd0, 5'd0, 5'd10, 32'd5, 32'd7, 32'd0, 4'b0010, 1'b0, 1'b0);
    MemRd = 5'd0; WbRd = 5'd0;
    tick();
    @(negedge clk);
    check("fwd_r0_I0", I0, 32'd5);

    // ALUSrc selects the immediate; store data still forwarded.
    instr(5'd1, 5'd4, 5'd10, 32'd5, 32'd7, 32'hFFFF_FFF0, 4'b0010, 1'b1, 1'b0);
    MemRegWrite = 0;
    tick();
    WbRegWrite = 1; WbRd = 5'd4; WbData = 32'd9;
    @(negedge clk);
    check("alusrc_I1", I1, 32'hFFFF_FFF0);
    check("alusrc_store", ExStoreData, 32'd9);

    // Load-use: lw r8 in EX, consumer of r8 in ID.
    WbRegWrite = 0;
    instr(5'd1, 5'd2, 5'd8, 32'd1, 32'd2, 32'd0, 4'b0010, 1'b0, 1'b1);
    tick();
    instr(5'd8, 5'd9, 5'd11, 32'd3, 32'd4, 32'd0, 4'b0010, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_stall", 32'(LoadUseStall), 32'd1);
`ifdef ID_EX_LOADUSE_CNT_EN
    check("lu_cnt0", 32'(LoadUseCount), 32'd0);
`endif
    tick();
    @(negedge clk);
    check("lu_bubble_valid", 32'(ExValid), 32'd0);
    check("lu_bubble_ctrl", 32'({ExRegWrite, ExMemRead, ExMemToReg, ALUControl}), 32'd0);
    check("lu_stall_drop", 32'(LoadUseStall), 32'd0);
`ifdef ID_EX_LOADUSE_CNT_EN
    check("lu_cnt1", 32'(LoadUseCount), 32'd1);
`endif

    // Stall refresh: WB value for r6 arrives and retires during the stall.
    instr(5'd6, 5'd7, 5'd12, 32'd1, 32'd2, 32'd0, 4'b0010, 1'b0, 1'b0);
    tick();
    Stall = 1; WbRegWrite = 1; WbRd = 5'd6; WbData = 32'd55;
    IdRs = 5'd13; IdRsData = 32'hDEAD_BEEF; IdALUControl = 4'b1100;
    @(negedge clk);
    check("stall_c1_I0", I0, 32'd55);
    tick();
    WbRegWrite = 0; WbData = 32'd77;
    @(negedge clk);
    check("stall_c2_I0", I0, 32'd55);
    tick();
    Stall = 0;
    @(negedge clk);
    check("stall_after_I0", I0, 32'd55);
    check("stall_hold_alu", 32'(ALUControl), 32'h2);
    check("stall_hold_valid", 32'(ExValid), 32'd1);

    // Flush beats Stall.
    instr(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 4'b0010, 1'b0, 1'b0);
    Stall = 1; Flush = 1;
    tick();
    Stall = 0; Flush = 0; IdValid = 0;
    @(negedge clk);
    check("flush_valid", 32'(ExValid), 32'd0);
    check("flush_alu", 32'(ALUControl), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      tick();
      rand_inputs();
    end
    tick();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
